hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage MIPS core.
- Drives the 2-bit forwarding selects of the EX-stage operand muxes and the decode-stage branch-compare forwarding selects.
- Generates load-use, branch and multiply/divide stalls and flushes.
- Sequences the multi-cycle multiply/divide unit in EX with a busy counter and a one-cycle completion pulse.

---
 rtl/hazard_ctrl.sv | 107 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: operand forwarding selects,
// load-use/branch/mul-div stalls and flushes, and the mul/div busy sequencer.
module hazard_ctrl #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic       BranchD,
  input  logic       MDStartD,
  input  logic       HiLoReadD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic       RegWriteE,
  input  logic       MemtoRegE,
  input  logic       MDStartE,
  input  logic [4:0] WriteRegM,
  input  logic       RegWriteM,
  input  logic       MemtoRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushE,
  output logic       MDBusyE,
  output logic       MDDoneE
);

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lwstall, branchstall, mdstall;

  // M-stage result is newer than W-stage, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (src != 5'd0 && RegWriteM && src == WriteRegM)
      return 2'b10;
    else if (src != 5'd0 && RegWriteW && src == WriteRegW)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  assign ForwardAE = fwd_sel(RsE);
  assign ForwardBE = fwd_sel(RtE);
  assign ForwardAD = (RsD != 5'd0) && RegWriteM && (RsD == WriteRegM);
  assign ForwardBD = (RtD != 5'd0) && RegWriteM && (RtD == WriteRegM);

  assign lwstall     = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
  assign branchstall = BranchD &&
                       ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                        (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
  assign mdstall     = MDBusyE && (MDStartD || HiLoReadD);

  assign StallF = !reset && (lwstall || branchstall || mdstall);
  assign StallD = StallF;
  assign FlushE = StallF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while busy is dropped; the D-stage stall prevents it in legal flow.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (MDStartE) begin
          cnt_d   = CNT_W'(MD_LATENCY - 1);
          state_d = MD_BUSY;
        end
      end
      MD_BUSY: begin
        if (cnt_q != '0)
          cnt_d = cnt_q - 1'b1;
        else
          state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign MDBusyE = (state_q == MD_BUSY);
  assign MDDoneE = MDBusyE && (cnt_q == '0);

endmodule
